// File: rtl/bd_rx_sequencer.sv
// Receive framer: SOF/length/payload parser feeding a payload FIFO, with a frame-done interrupt. Optional BD_RX_CHECKSUM_EN adds an XOR check byte.
// Latency: a byte pushed into an empty FIFO is on data_out one cycle later; the interrupt rises one cycle after DONE.
// Backpressure: ready_out low holds data_out; a push into a full FIFO with no pop drops the byte, flags overflow and aborts the frame.
module bd_rx_sequencer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  SOF_BYTE   = 8'h7E,
    parameter int          MAX_LEN    = 16
) (
    input  logic       G_CLK_RX,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       dec_valid,
    input  logic [7:0] dec_data,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       int_rx_host,
    input  logic       int_ack,
    output logic       BD_CONTROL,
`ifdef BD_RX_CHECKSUM_EN
    output logic [2:0] rx_err
`else
    output logic [1:0] rx_err
`endif
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     MAX_L   = 8'(MAX_LEN);
`ifdef BD_RX_CHECKSUM_EN
    localparam int             ERR_W   = 3;
`else
    localparam int             ERR_W   = 2;
`endif

`ifdef BD_RX_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cnt_inc;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              accept, pop, full, push_req, push, ovf;
    logic              len_err, irq_set;
    logic [ERR_W-1:0]  err_set;
`ifdef BD_RX_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
    logic              chk_err;
`endif

    assign accept    = rx_enable && dec_valid;
    assign valid_out = (count != '0);
    assign data_out  = valid_out ? mem[rd_ptr] : 8'h00;
    assign pop       = valid_out && ready_out;
    assign full      = (count == DEPTH_C);
    assign cnt_inc   = cnt_q + 8'd1;
    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
    assign push      = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        push_req = 1'b0;
        len_err  = 1'b0;
        irq_set  = 1'b0;
`ifdef BD_RX_CHECKSUM_EN
        chk_d    = chk_q;
        chk_err  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && dec_data == SOF_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    len_d = dec_data;
                    cnt_d = 8'd0;
`ifdef BD_RX_CHECKSUM_EN
                    chk_d = 8'd0;
`endif
                    if (dec_data == 8'd0 || dec_data > MAX_L) begin
                        len_err = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    push_req = 1'b1;
                    cnt_d    = cnt_inc;
`ifdef BD_RX_CHECKSUM_EN
                    chk_d    = chk_q ^ dec_data;
`endif
                    if (full && !pop) begin
                        state_d = S_IDLE;
                    end else if (cnt_inc == len_q) begin
`ifdef BD_RX_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef BD_RX_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (dec_data == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        chk_err = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_DONE: begin
                irq_set = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling the receiver abandons any frame, including a pending DONE.
        if (!rx_enable) begin
            state_d = S_IDLE;
            irq_set = 1'b0;
        end
    end

    always_comb begin
        err_set    = '0;
        err_set[0] = len_err;
        err_set[1] = ovf;
`ifdef BD_RX_CHECKSUM_EN
        err_set[2] = chk_err;
`endif
    end

    always_ff @(posedge G_CLK_RX) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            int_rx_host <= 1'b0;
            BD_CONTROL  <= 1'b0;
            rx_err      <= '0;
`ifdef BD_RX_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            BD_CONTROL <= rx_enable;
            rx_err     <= rx_err | err_set;
`ifdef BD_RX_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (irq_set)      int_rx_host <= 1'b1;
            else if (int_ack) int_rx_host <= 1'b0;
        end
    end

    always_ff @(posedge G_CLK_RX) begin
        if (!reset && push) mem[wr_ptr] <= dec_data;
    end

endmodule
